ext_bus_seq: RTL
================

// Module: ext_bus_seq
// PURPOSE
// Parametrised external-bus cycle sequencer that replaces the purely combinational
// cartridge-bus glue with a clocked FSM. It accepts CPU and DMA transfer requests
// and drives the external address, data, /RD, /WR and /CS pins with setup, strobe,
// programmable wait and hold phases. Read data is latched and returned.
// It sits between the CPU core / DMA engine and the cartridge connector pads.
// PARAMETERS
// AW        16      external address width (bits)
// DW        8       external data width (bits)
// WAIT_W    2       width of the wait-state count; 0..2**WAIT_W-1 extra strobe cycles
// CS_MATCH  'hA000  address value that selects the cartridge-RAM chip select
// CS_MASK   'hE000  bits of addr compared against CS_MATCH
// PORTS
// clk          in   1       system clock; all state changes on rising edge
// nreset       in   1       synchronous, active-low reset
// cpu_req      in   1       CPU transfer request; held until cpu_ack
// cpu_we       in   1       1=write, 0=read; sampled when request is accepted
// cpu_a        in   AW      CPU address
// cpu_wdata    in   DW      CPU write data
// cpu_ack      out  1       1-cycle pulse: transfer complete
// cpu_rdata    out  DW      latched read data; valid from cpu_ack, held until next read
// dma_req      in   1       DMA read request (DMA_EN only; tie 0 otherwise)
// dma_a        in   AW      DMA source address
// dma_ack      out  1       1-cycle pulse: DMA read complete; data on cpu_rdata
// wait_cycles  in   WAIT_W  extra strobe cycles; sampled at acceptance
// ext_a        out  AW      external address pins
// ext_d_out    out  DW      external data out
// ext_d_oe     out  1       external data output enable
// ext_d_in     in   DW      external data in
// ext_rd_n     out  1       external read strobe, active low
// ext_wr_n     out  1       external write strobe, active low
// ext_cs_n     out  1       cartridge-RAM chip select, active low
// busy         out  1       1 whenever the FSM is not IDLE
// BEHAVIOUR
// - Reset (nreset=0 at edge): FSM->IDLE; ext_rd_n=ext_wr_n=ext_cs_n=1, ext_d_oe=0,
//   ext_a=0, ext_d_out=0, cpu_rdata=0, cpu_ack=dma_ack=0, busy=0. Reset mid-cycle
//   aborts the transfer and issues no ack.
// - States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE/SETUP.
// - IDLE: if dma_req, accept DMA (read); else if cpu_req, accept CPU.
//   DMA has priority. Acceptance latches addr, we, wdata and wait_cycles into
//   internal registers. Goes to SETUP.
// - SETUP (1 clk): ext_a=latched addr; ext_cs_n=!((addr&CS_MASK)==(CS_MATCH&CS_MASK));
//   for writes ext_d_oe=1 and ext_d_out=wdata; strobes stay high.
// - STROBE (1+wait clks): the wait counter loads the latched wait value and decrements
//   to 0. ext_rd_n=0 (read) or ext_wr_n=0 (write). On the last STROBE edge a read
//   captures ext_d_in into cpu_rdata.
// - HOLD (1 clk): strobes=1; ext_a, ext_cs_n and ext_d_oe/ext_d_out are held; the
//   owner's ack=1. At exit, if another request is pending (same priority rule),
//   go directly to SETUP, else IDLE with ext_cs_n=1 and ext_d_oe=0.
// - ext_a keeps the last address in IDLE; it does not return to 0.
// - Latency: acceptance edge to ack = 3+wait clks. Back-to-back transfers take 3+wait clks each.
// - cpu_ack/dma_ack never assert together; at most one transfer is in flight.
// - Requests changing after acceptance have no effect on the current cycle.
// - ext_rd_n and ext_wr_n never both 0; ext_d_oe=0 for every read cycle.
// - wait_cycles at max (2**WAIT_W-1) gives a STROBE of 2**WAIT_W clks; the counter
//   does not wrap.
// CONFIGURATION
// - EXT_BUS_DMA_EN defined: DMA port active with priority as above.
// - EXT_BUS_DMA_EN undefined: dma_req is ignored, dma_ack is tied 0, and only CPU
//   transfers run. Timing is otherwise identical.
// TESTING
// - CPU read a=0xA123, wait=0, ext_d_in=0x5A -> rd_n low 1 clk, cs_n=0, ack at clk 3,
//   cpu_rdata=0x5A.
// - CPU write a=0x2000, d=0x0F, wait=3 -> wr_n low 4 clks, d_oe 1 SETUP..HOLD,
//   cs_n=1, ack at clk 6.
// - cpu_req and dma_req (a=0xC000) raised together -> DMA served first (dma_ack),
//   then CPU with no IDLE gap.
// - Two CPU reads held back-to-back -> acks 3 clks apart; cpu_rdata updates only on
//   read captures.
// - nreset=0 during STROBE of a write -> next clk: wr_n=1, d_oe=0, no ack, busy=0.
// - EXT_BUS_DMA_EN off, dma_req=1 -> no external cycle, dma_ack stays 0.

Source files
------------

// File: rtl/ext_bus_seq.sv
// rtl/ext_bus_seq.sv - clocked external-bus cycle sequencer (setup/strobe/wait/hold)
//
// Sequences CPU and DMA transfers onto the cartridge connector pins. Each
// transfer runs SETUP (1 clk), STROBE (1+wait clks) and HOLD (1 clk). The
// owner's ack is asserted during HOLD. Read data is captured on the last
// STROBE edge and held on cpu_rdata until the next read capture.
//
// Optional feature macro: EXT_BUS_DMA_EN
//   defined   - DMA read port active; DMA wins over CPU when both request
//   undefined - dma_req/dma_a ignored, dma_ack tied 0
//
// Ports:
//   clk, nreset                 clock, synchronous active-low reset
//   cpu_req/cpu_we/cpu_a/
//   cpu_wdata                   CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata          CPU completion pulse, latched read data
//   dma_req/dma_a, dma_ack      DMA read request and completion pulse
//   wait_cycles                 extra strobe clocks, sampled at acceptance
//   ext_a/ext_d_out/ext_d_oe/
//   ext_d_in                    external address and data pins
//   ext_rd_n/ext_wr_n/ext_cs_n  external active-low strobes and chip select
//   busy                        FSM not idle

module ext_bus_seq #(
    parameter int            AW       = 16,
    parameter int            DW       = 8,
    parameter int            WAIT_W   = 2,
    parameter logic [AW-1:0] CS_MATCH = 'hA000,
    parameter logic [AW-1:0] CS_MASK  = 'hE000
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_a,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_ack,
    output logic [DW-1:0]     cpu_rdata,
    input  logic              dma_req,
    input  logic [AW-1:0]     dma_a,
    output logic              dma_ack,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic [AW-1:0]     ext_a,
    output logic [DW-1:0]     ext_d_out,
    output logic              ext_d_oe,
    input  logic [DW-1:0]     ext_d_in,
    output logic              ext_rd_n,
    output logic              ext_wr_n,
    output logic              ext_cs_n,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                dma_sel;
    logic                take;
    logic                lat_dma;
    logic                lat_we;
    logic [AW-1:0]       lat_a;
    logic [DW-1:0]       lat_wdata;
    logic [WAIT_W-1:0]   lat_wait;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DW-1:0]       rdata_q;
    logic                strobe_last;
    logic                cs_hit;

`ifdef EXT_BUS_DMA_EN
    assign dma_sel = dma_req;
`else
    logic unused_dma;
    assign unused_dma = dma_req;
    assign dma_sel    = 1'b0;
`endif

    // A new transfer can start from IDLE, or straight out of HOLD so that
    // back-to-back requests see no idle gap.
    assign take        = ((state == IDLE) || (state == HOLD)) && (dma_sel || cpu_req);
    assign strobe_last = (state == STROBE) && (wait_cnt == '0);
    assign cs_hit      = ((lat_a & CS_MASK) == (CS_MATCH & CS_MASK));

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = take ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = strobe_last ? HOLD : STROBE;
            HOLD:    state_next = take ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer latches, wait counter and read capture
    always_ff @(posedge clk) begin
        if (!nreset) begin
            lat_dma   <= 1'b0;
            lat_we    <= 1'b0;
            lat_a     <= '0;
            lat_wdata <= '0;
            lat_wait  <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
        end else begin
            if (take) begin
                lat_dma   <= dma_sel;
                lat_we    <= dma_sel ? 1'b0 : cpu_we;
                lat_a     <= dma_sel ? dma_a : cpu_a;
                lat_wdata <= cpu_wdata;
                lat_wait  <= wait_cycles;
            end
            // Counter loads on the SETUP edge and only counts down while
            // nonzero, so the maximum wait value never wraps.
            if (state == SETUP) begin
                wait_cnt <= lat_wait;
            end else if ((state == STROBE) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (strobe_last && !lat_we) begin
                rdata_q <= ext_d_in;
            end
        end
    end

    // Output logic; ext_a and ext_d_out come straight from the latches so
    // the last address stays on the pins while idle.
    always_comb begin
        busy      = (state != IDLE);
        ext_a     = lat_a;
        ext_d_out = lat_wdata;
        ext_d_oe  = busy && lat_we;
        ext_cs_n  = !(busy && cs_hit);
        ext_rd_n  = !((state == STROBE) && !lat_we);
        ext_wr_n  = !((state == STROBE) && lat_we);
        cpu_rdata = rdata_q;
        cpu_ack   = (state == HOLD) && !lat_dma;
`ifdef EXT_BUS_DMA_EN
        dma_ack   = (state == HOLD) && lat_dma;
`else
        dma_ack   = 1'b0;
`endif
    end

endmodule
